// File: rtl/ram_rd_stream.sv
// ram_rd_stream: reads a burst of consecutive RAM words and presents them
// on a valid/ready stream through a small first-word-fall-through FIFO.
// Requests are throttled so that words already in the FIFO plus reads still
// in the two-cycle RAM pipeline never exceed FIFO_DEPTH. This means a stalled
// consumer can never cause an overflow.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   cfg_start           one-cycle burst request, honoured only while idle
//   cfg_base_addr       first RAM address of the burst
//   cfg_len             number of words, 0..2^ADDR_WIDTH
//   busy, done          burst in progress / one-cycle completion pulse
//   ram_read_req/addr   RAM read port; ram_read_data returns 2 cycles later
//   m_valid/ready/data  output stream, m_last marks the final burst word

module ram_rd_stream #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_read_req,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic [LEN_W-1:0]      len, issued, remaining;
  logic [1:0]            vld_pipe, last_pipe;
  logic [1:0]            inflight;
  logic [OCC_W-1:0]      occupancy;
  logic                  issue, issue_last, push, pop;

  logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0]   head;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  // Pointer advance with wrap, valid for non power-of-two depths too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign remaining  = len - issued;
  assign inflight   = {1'b0, vld_pipe[0]} + {1'b0, vld_pipe[1]};
  assign occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight);
  // No credit for a same-cycle pop: the request decision uses registered state only.
  assign issue      = (state == RUN) && (remaining != {LEN_W{1'b0}}) &&
                      (occupancy < OCC_W'(FIFO_DEPTH));
  assign issue_last = issue && (remaining == LEN_W'(1));
  assign push       = vld_pipe[1];
  assign pop        = m_valid && m_ready;
  assign head       = fifo_mem[rd_ptr];

  // Burst state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt = (cfg_len != {LEN_W{1'b0}}) ? RUN : FINISH;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (issue_last) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_nxt = FINISH;
        end else begin
          state_nxt = DRAIN;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status, RAM port and stream head outputs, all decoded from registers.
  always_comb begin
    busy          = (state == RUN) || (state == DRAIN);
    done          = (state == FINISH);
    ram_read_req  = issue;
    ram_read_addr = base + issued[ADDR_WIDTH-1:0];
    m_valid       = (fifo_count != {CNT_W{1'b0}});
    // An empty FIFO shows zeros so stale entries never leak after reset.
    if (m_valid) begin
      m_data = head[DATA_WIDTH-1:0];
      m_last = head[DATA_WIDTH];
    end else begin
      m_data = {DATA_WIDTH{1'b0}};
      m_last = 1'b0;
    end
  end

  // Burst parameters and issued-word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base   <= {ADDR_WIDTH{1'b0}};
      len    <= {LEN_W{1'b0}};
      issued <= {LEN_W{1'b0}};
    end else if ((state == IDLE) && cfg_start) begin
      base   <= cfg_base_addr;
      len    <= cfg_len;
      issued <= {LEN_W{1'b0}};
    end else if (issue) begin
      issued <= issued + LEN_W'(1);
    end
  end

  // Two-stage valid/last pipeline aligned with the RAM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= 2'b00;
      last_pipe <= 2'b00;
    end else begin
      vld_pipe  <= {vld_pipe[0], issue};
      last_pipe <= {last_pipe[0], issue_last};
    end
  end

  // FIFO storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {last_pipe[1], ram_read_data};
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= {PTR_W{1'b0}};
      rd_ptr     <= {PTR_W{1'b0}};
      fifo_count <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  ram_rd_stream_chk #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .count (fifo_count)
  );

endmodule

// ram_rd_stream_chk: simulation checks for ram_rd_stream.
// Ports: clk, rst_n, push (FIFO write strobe), count (FIFO occupancy).
module ram_rd_stream_chk #(
  parameter int CNT_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push,
  input logic [CNT_W-1:0] count
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == CNT_W'(FIFO_DEPTH))))
    else $error("ram_rd_stream FIFO written while full");

endmodule

// File: tb/tb_ram_rd_stream.sv
// Self-checking bench for ram_rd_stream: a RAM model with 2-cycle read latency,
// a queue-based reference of expected addresses and words, and directed plus
// randomized bursts.
module tb_ram_rd_stream;

  localparam int DW    = 10;
  localparam int AW    = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n, cfg_start, busy, done, ram_read_req, m_valid, m_ready, m_last;
  logic [AW-1:0] cfg_base_addr, ram_read_addr;
  logic [AW:0]   cfg_len;
  logic [DW-1:0] ram_read_data, m_data;

  ram_rd_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_len(cfg_len), .busy(busy), .done(done), .ram_read_req(ram_read_req),
    .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data for the address requested in cycle R is visible in R+2.
  logic [DW-1:0] mem [1 << AW];
  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [AW-1:0] p1_a = '0, p2_a = '0;
  logic [DW-1:0] noise = '0;
  always @(posedge clk) begin
    p1_v  <= ram_read_req;
    p1_a  <= ram_read_addr;
    p2_v  <= p1_v;
    p2_a  <= p1_a;
    noise <= DW'($urandom);
  end
  assign ram_read_data = p2_v ? mem[p2_a] : noise;

  int checks = 0, errors = 0;
  int ready_mode = 0;  // 0: always ready, 1: never ready, 2: random
  logic [AW-1:0] exp_addr[$];
  logic [DW:0]   exp_word[$];
  int req_cyc[$], hs_cyc[$], done_cyc[$];
  int req_total = 0, pop_total = 0, valid_total = 0, start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // m_ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every request and handshake with the reference queues.
  initial begin
    bit          prev_stall = 1'b0;
    logic [DW:0] prev_word = '0;
    logic [DW:0] w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (ram_read_req) begin
        req_cyc.push_back(cyc);
        check("outstanding_le_depth", 32'((req_total + 1 - pop_total) <= DEPTH), 32'(1));
        req_total++;
        if (exp_addr.size() == 0) check("extra_req", 32'(ram_read_req), 32'(0));
        else check("rd_addr", 32'(ram_read_addr), 32'(exp_addr.pop_front()));
      end
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'(1));
        check("stall_word", 32'({m_last, m_data}), 32'(prev_word));
      end
      if (m_valid && m_ready) begin
        hs_cyc.push_back(cyc);
        pop_total++;
        if (exp_word.size() == 0) check("extra_word", 32'(m_valid), 32'(0));
        else begin
          w = exp_word.pop_front();
          check("m_data", 32'(m_data), 32'(w[DW-1:0]));
          check("m_last", 32'(m_last), 32'(w[DW]));
        end
      end
      if (m_valid) valid_total++;
      if (done) begin
        done_cyc.push_back(cyc);
        check("busy_low_at_done", 32'(busy), 32'(0));
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end
  end

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk);
    #1;
    exp_addr.delete(); exp_word.delete();
    req_cyc.delete(); hs_cyc.delete(); done_cyc.delete();
    for (int i = 0; i < int'(l); i++) begin
      logic [AW-1:0] a;
      a = AW'((int'(b) + i) % (1 << AW));
      exp_addr.push_back(a);
      exp_word.push_back({(i == int'(l) - 1), mem[a]});
    end
    valid_total = 0;
    start_cyc = cyc;
    cfg_start = 1'b1; cfg_base_addr = b; cfg_len = l;
    @(posedge clk);
    #1;
    cfg_start = 1'b0; cfg_base_addr = AW'($urandom); cfg_len = (AW + 1)'($urandom);
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'(l != 0));
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cyc.size()), 32'(1));
  endtask

  task automatic finish_checks(input int l, input bit strict);
    check("req_count", 32'(req_cyc.size()), 32'(l));
    check("word_count", 32'(hs_cyc.size()), 32'(l));
    check("words_left", 32'(exp_word.size()), 32'(0));
    if (done_cyc.size() > 0) begin
      if (l == 0) begin
        check("done_after_len0", 32'(done_cyc[0]), 32'(start_cyc + 1));
        check("no_valid_len0", 32'(valid_total), 32'(0));
      end else if (hs_cyc.size() > 0) begin
        check("done_after_last", 32'(done_cyc[0]), 32'(hs_cyc[hs_cyc.size() - 1] + 1));
      end
    end
    if (strict && l > 0 && req_cyc.size() == l && hs_cyc.size() == l) begin
      check("first_req_latency", 32'(req_cyc[0]), 32'(start_cyc + 1));
      check("first_valid_latency", 32'(hs_cyc[0]), 32'(req_cyc[0] + 3));
      for (int i = 1; i < l; i++) begin
        check("req_consecutive", 32'(req_cyc[i]), 32'(req_cyc[0] + i));
        check("word_consecutive", 32'(hs_cyc[i]), 32'(hs_cyc[0] + i));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    rst_n = 1'b0; cfg_start = 1'b0; cfg_base_addr = '0; cfg_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({busy, done, ram_read_req, ram_read_addr, m_valid, m_data, m_last}), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // basic burst, consumer always ready
    start_burst(12'h010, 13'd5);
    wait_done(100);
    finish_checks(5, 1'b1);

    // address wrap at the top of the RAM
    start_burst(12'hFFE, 13'd4);
    wait_done(100);
    finish_checks(4, 1'b1);

    // consumer stalled: exactly FIFO_DEPTH reads, then released
    ready_mode = 1;
    repeat (2) @(posedge clk);
    start_burst(12'h100, 13'd8);
    repeat (20) @(negedge clk);
    check("stalled_req_count", 32'(req_cyc.size()), 32'(DEPTH));
    check("stalled_req_low", 32'(ram_read_req), 32'(0));
    check("stalled_head_valid", 32'(m_valid), 32'(1));
    check("stalled_head_data", 32'(m_data), 32'(mem[12'h100]));
    ready_mode = 0;
    wait_done(200);
    finish_checks(8, 1'b0);

    // zero-length burst
    start_burst(12'h123, 13'd0);
    wait_done(20);
    finish_checks(0, 1'b0);

    // random backpressure, long bursts, ignored mid-burst start
    ready_mode = 2;
    for (int n = 0; n < 2; n++) begin
      start_burst(AW'($urandom), 13'd64);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1 cfg_start = 1'b1; cfg_len = 13'd5; cfg_base_addr = AW'($urandom);
      @(posedge clk);
      #1 cfg_start = 1'b0;
      wait_done(2000);
      finish_checks(64, 1'b0);
    end
    for (int n = 0; n < 4; n++) begin
      start_burst(AW'($urandom), 13'($urandom_range(1, 40)));
      wait_done(2000);
      finish_checks(exp_addr.size() + req_cyc.size(), 1'b0);
    end

    // reset mid-burst with two reads in flight
    ready_mode = 0;
    repeat (2) @(posedge clk);
    start_burst(12'h200, 13'd16);
    for (int i = 0; i < 50 && req_cyc.size() < 2; i++) @(negedge clk);
    check("reads_before_reset", 32'(req_cyc.size() >= 2), 32'(1));
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_outputs", 32'({busy, done, ram_read_req, ram_read_addr, m_valid, m_data, m_last}), 32'(0));
    @(posedge clk);
    #1;
    exp_addr.delete(); exp_word.delete(); hs_cyc.delete(); done_cyc.delete();
    req_total = 0; pop_total = 0; valid_total = 0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_stale_valid", 32'(valid_total), 32'(0));
    check("no_done_after_abort", 32'(done_cyc.size()), 32'(0));
    start_burst(12'h300, 13'd6);
    wait_done(100);
    finish_checks(6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
